ioctl_sdram_bridge: RTL and testbench
=====================================

IOCTL_SDRAM_BRIDGE -- requirements
Module: ioctl_sdram_bridge

Interface
REQ-001 Parameter: FIFO_DEPTH, default 4, word FIFO depth; power of two, range 4..16.
REQ-002 Parameter: ADDR_W, default 24, width of the word address on the memory port.
REQ-003 Port: clk_sys  in  1  system clock; the only clock; all logic on its rising edge.
REQ-004 Port: rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port: ioctl_download  in  1  download active, level.
REQ-006 Port: ioctl_wr  in  1  one-cycle byte strobe.
REQ-007 Port: ioctl_addr  in  27  byte address of ioctl_dout.
REQ-008 Port: ioctl_dout  in  8  download byte.
REQ-009 Port: clkref_n  out  1  throttle to the download source; low means one byte may be accepted.
REQ-010 Port: mem_req  out  1  write request, level.
REQ-011 Port: mem_ack  in  1  one-cycle acknowledge from the memory controller.
REQ-012 Port: mem_addr  out  ADDR_W  word address, ioctl_addr[ADDR_W:1].
REQ-013 Port: mem_din  out  16  write data; even byte on [7:0], odd byte on [15:8].
REQ-014 Port: mem_be  out  2  byte enables; [0] = low byte, [1] = high byte.
REQ-015 Port: dl_done  out  1  one-cycle pulse when a download is fully committed to memory.
REQ-016 Port: overflow  out  1  sticky flag: a byte was dropped.
REQ-017 Port: byte_count  out  27  bytes accepted in the current download.

Function
REQ-018 The block SHALL hold at most one pending byte (valid, word address, data, lane).
REQ-019 Even-address ioctl_wr with no pending byte: SHALL store it as pending, lane 0.
REQ-020 Even-address ioctl_wr with a pending byte: SHALL push the pending byte with be=01 and make the new byte pending, in the same cycle.
REQ-021 Odd-address ioctl_wr matching the pending word address: SHALL push {new,pending} with be=11 and clear pending.
REQ-022 Odd-address ioctl_wr with no matching pending byte: SHALL push any pending byte (be=01) and SHALL NOT push the new byte that cycle; the new byte is pushed on the next cycle as {byte,8'h00} with be=10.
REQ-023 The block SHALL push at most one FIFO word per cycle.
REQ-024 Every accepted ioctl_wr SHALL increment byte_count by 1.
REQ-025 If the FIFO is full when a push is due, the word SHALL be dropped, overflow set, and byte_count still incremented.
REQ-026 clkref_n SHALL be low iff FIFO occupancy <= FIFO_DEPTH-3 and no deferred odd byte is outstanding; registered, updated every cycle.
REQ-027 mem_req SHALL assert the cycle after the FIFO becomes non-empty while the memory port is idle.
REQ-028 mem_addr/mem_din/mem_be SHALL stay stable while mem_req is high.
REQ-029 On mem_ack with mem_req high, the block SHALL pop the head, drop mem_req the next cycle, and hold it low for at least one cycle.
REQ-030 mem_ack while mem_req is low SHALL be ignored.
REQ-031 FSM states: IDLE, RUN, FLUSH, DRAIN. Transitions:
- IDLE->RUN on rising ioctl_download.
- RUN->FLUSH on falling ioctl_download.
- FLUSH pushes any pending byte (be=01), then goes to DRAIN.
- DRAIN->IDLE when the FIFO is empty and mem_req is low; dl_done pulses on that transition.
REQ-032 Rising ioctl_download SHALL clear pending, byte_count and overflow, from any state. The FIFO is not flushed; outstanding words still drain.
REQ-033 ioctl_wr outside RUN SHALL be ignored and SHALL NOT count.
REQ-034 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy uses a separate counter of width log2(FIFO_DEPTH)+1.
REQ-035 Simultaneous push and pop on a full FIFO SHALL succeed without overflow.

Reset
REQ-036 While rst_n is low at a clk_sys edge:
- FSM returns to IDLE; FIFO and pending are emptied.
- mem_req=0, mem_be=0, mem_addr=0, mem_din=0.
- clkref_n=0, dl_done=0, overflow=0, byte_count=0.
REQ-037 A reset during an outstanding mem_req SHALL abandon that request; a later mem_ack SHALL be ignored.

Verification
REQ-038 Download bytes 0x11,0x22,0x33,0x44 at addresses 0..3, ack after 2 cycles -> two requests: addr 0, din 0x2211, be 11; then addr 1, din 0x4433, be 11; dl_done once; byte_count=4.
REQ-039 Odd-length download: 3 bytes at 0..2, then ioctl_download falls -> final request addr 1, din[7:0]=byte2, be 01, then dl_done.
REQ-040 Single write at address 5 (0xAB) -> one request: addr 2, din 0xAB00, be 10.
REQ-041 mem_ack held low with continuous ioctl_wr, FIFO_DEPTH=4 -> clkref_n goes high at occupancy 2, no overflow; after acks resume, all words are written in order.
REQ-042 Forced ioctl_wr into a full FIFO (clkref_n ignored) -> overflow=1 and stays 1; a new download start clears it.
REQ-043 rst_n low for 1 cycle while mem_req=1 -> mem_req=0 the next cycle; a stray mem_ack afterwards causes no pop and no dl_done.

Source files
------------

// File: rtl/ioctl_sdram_bridge.sv
// ioctl_sdram_bridge
// Packs the byte-wide ioctl download stream into 16-bit words and writes them
// to an SDRAM controller through a small word FIFO.
//
// Ports:
//   clk_sys, rst_n         - system clock, synchronous active-low reset
//   ioctl_download         - download active (level)
//   ioctl_wr               - one-cycle byte strobe
//   ioctl_addr/ioctl_dout  - byte address and data of the strobed byte
//   clkref_n               - throttle; low means the source may send one byte
//   mem_req/mem_ack        - level request, one-cycle acknowledge
//   mem_addr/mem_din/mem_be- word address, data (even byte low), byte enables
//   dl_done                - pulse once a download is fully committed
//   overflow               - sticky: a word was dropped on a full FIFO
//   byte_count             - bytes accepted in the current download
module ioctl_sdram_bridge #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 24
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [26:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic              clkref_n,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic [1:0]        mem_be,
    output logic              dl_done,
    output logic              overflow,
    output logic [26:0]       byte_count
);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int WORD_W = ADDR_W + 18;   // {addr, din, be}
    localparam logic [CNT_W-1:0] FULL_LVL     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] THROTTLE_LVL = CNT_W'(FIFO_DEPTH - 3);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [1:0]        state_reg, state_next;
    logic              dl_prev_reg;
    logic              dl_done_reg, dl_done_next;
    logic              pend_valid_reg;
    logic [ADDR_W-1:0] pend_addr_reg;
    logic [7:0]        pend_data_reg;
    logic              defer_valid_reg;
    logic [ADDR_W-1:0] defer_addr_reg;
    logic [7:0]        defer_data_reg;
    logic [WORD_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              clkref_n_reg, overflow_reg;
    logic [26:0]       byte_count_reg;
    logic              mem_req_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [15:0]       mem_din_reg;
    logic [1:0]        mem_be_reg;

    logic              dl_rise, dl_fall, wr_acc, pop, do_push;
    logic              push_valid, pend_load, pend_clear, defer_load;
    logic [WORD_W-1:0] push_word;
    logic [ADDR_W-1:0] wr_waddr;

    assign wr_waddr = ioctl_addr[ADDR_W:1];
    assign dl_rise  = ioctl_download & ~dl_prev_reg;
    assign dl_fall  = ~ioctl_download & dl_prev_reg;
    assign wr_acc   = ioctl_wr && (state_reg == ST_RUN);
    assign pop      = mem_req_reg && mem_ack;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the push.
    assign do_push  = push_valid && ((count_reg != FULL_LVL) || pop);
    assign count_next = count_reg + CNT_W'(do_push) - CNT_W'(pop);

    generate
        if (ADDR_W < 26) begin : g_addr_unused
            logic unused_addr_hi;
            assign unused_addr_hi = ^ioctl_addr[26:ADDR_W+1];
        end
    endgenerate

    // Byte pairing. A deferred odd byte is only ever created in a cycle that
    // also empties the pending slot, so deferred and pending are never valid
    // together and at most one word is pushed per cycle.
    always_comb begin
        push_valid = 1'b0;
        push_word  = '0;
        pend_load  = 1'b0;
        pend_clear = 1'b0;
        defer_load = 1'b0;
        if (defer_valid_reg) begin
            push_valid = 1'b1;
            push_word  = {defer_addr_reg, defer_data_reg, 8'h00, 2'b10};
        end
        if (wr_acc) begin
            if (!ioctl_addr[0]) begin
                if (pend_valid_reg) begin
                    push_valid = 1'b1;
                    push_word  = {pend_addr_reg, 8'h00, pend_data_reg, 2'b01};
                end
                pend_load = 1'b1;
            end else if (pend_valid_reg && (pend_addr_reg == wr_waddr)) begin
                push_valid = 1'b1;
                push_word  = {wr_waddr, ioctl_dout, pend_data_reg, 2'b11};
                pend_clear = 1'b1;
            end else begin
                if (pend_valid_reg) begin
                    push_valid = 1'b1;
                    push_word  = {pend_addr_reg, 8'h00, pend_data_reg, 2'b01};
                end
                pend_clear = 1'b1;
                defer_load = 1'b1;
            end
        end
        if ((state_reg == ST_FLUSH) && pend_valid_reg && !defer_valid_reg && !dl_rise) begin
            push_valid = 1'b1;
            push_word  = {pend_addr_reg, 8'h00, pend_data_reg, 2'b01};
            pend_clear = 1'b1;
        end
    end

    // A new download restarts the sequence from whatever state we are in.
    always_comb begin
        state_next   = state_reg;
        dl_done_next = 1'b0;
        if (dl_rise) begin
            state_next = ST_RUN;
        end else begin
            case (state_reg)
                ST_RUN:   if (dl_fall) state_next = ST_FLUSH;
                ST_FLUSH: state_next = ST_DRAIN;
                ST_DRAIN: begin
                    if ((count_reg == '0) && !mem_req_reg) begin
                        state_next   = ST_IDLE;
                        dl_done_next = 1'b1;
                    end
                end
                default:  state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            dl_prev_reg     <= 1'b0;
            dl_done_reg     <= 1'b0;
            pend_valid_reg  <= 1'b0;
            pend_addr_reg   <= '0;
            pend_data_reg   <= '0;
            defer_valid_reg <= 1'b0;
            defer_addr_reg  <= '0;
            defer_data_reg  <= '0;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            clkref_n_reg    <= 1'b0;
            overflow_reg    <= 1'b0;
            byte_count_reg  <= '0;
            mem_req_reg     <= 1'b0;
            mem_addr_reg    <= '0;
            mem_din_reg     <= '0;
            mem_be_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            dl_prev_reg     <= ioctl_download;
            dl_done_reg     <= dl_done_next;
            defer_valid_reg <= defer_load;
            if (defer_load) begin
                defer_addr_reg <= wr_waddr;
                defer_data_reg <= ioctl_dout;
            end
            if (dl_rise) begin
                pend_valid_reg <= 1'b0;
            end else if (pend_load) begin
                pend_valid_reg <= 1'b1;
                pend_addr_reg  <= wr_waddr;
                pend_data_reg  <= ioctl_dout;
            end else if (pend_clear) begin
                pend_valid_reg <= 1'b0;
            end
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
            // Built from next-state values so the throttle tracks the
            // occupancy the source will see on its next byte.
            clkref_n_reg <= !((count_next <= THROTTLE_LVL) && !defer_load);
            if (dl_rise)                        overflow_reg <= 1'b0;
            else if (push_valid && !do_push)    overflow_reg <= 1'b1;
            if (dl_rise)     byte_count_reg <= '0;
            else if (wr_acc) byte_count_reg <= byte_count_reg + 27'd1;
            // Request launch latches the head word; it stays put until acked.
            if (mem_req_reg) begin
                if (mem_ack) mem_req_reg <= 1'b0;
            end else if (count_reg != '0) begin
                mem_req_reg <= 1'b1;
                {mem_addr_reg, mem_din_reg, mem_be_reg} <= fifo_mem[rd_ptr_reg];
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (rst_n && do_push) fifo_mem[wr_ptr_reg] <= push_word;
    end

    assign clkref_n   = clkref_n_reg;
    assign mem_req    = mem_req_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_din    = mem_din_reg;
    assign mem_be     = mem_be_reg;
    assign dl_done    = dl_done_reg;
    assign overflow   = overflow_reg;
    assign byte_count = byte_count_reg;
endmodule

// File: tb/tb_ioctl_sdram_bridge.sv
// Testbench for ioctl_sdram_bridge: directed scenarios plus randomized
// downloads compared against a byte-stream reference model.
module tb_ioctl_sdram_bridge;
    localparam int DEPTH = 4;
    localparam int AW    = 24;
    typedef logic [AW+17:0] word_t;

    logic          clk_sys = 1'b0;
    logic          rst_n = 1'b0;
    logic          ioctl_download = 1'b0;
    logic          ioctl_wr = 1'b0;
    logic [26:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_dout = '0;
    logic          clkref_n, mem_req, mem_ack, dl_done, overflow;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_din;
    logic [1:0]    mem_be;
    logic [26:0]   byte_count;
    logic          ack_resp = 1'b0;
    logic          stray_ack = 1'b0;
    logic          ack_en = 1'b0;

    assign mem_ack = ack_resp | stray_ack;

    ioctl_sdram_bridge #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .clkref_n(clkref_n), .mem_req(mem_req), .mem_ack(mem_ack),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be),
        .dl_done(dl_done), .overflow(overflow), .byte_count(byte_count)
    );

    always #5 clk_sys = ~clk_sys;

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];
    word_t cap_q[$];
    int    dl_done_cnt = 0;
    int    unstable_cnt = 0;
    int    ack_viol = 0;

    // Memory-side responder: acks a request on its second sampled cycle,
    // records the written word, and watches request stability.
    initial begin
        int    wait_cnt;
        bit    seen, acked;
        word_t first_word, cur;
        wait_cnt = 0; seen = 0; acked = 0; first_word = '0;
        forever begin
            @(negedge clk_sys);
            ack_resp = 1'b0;
            if (dl_done === 1'b1) dl_done_cnt++;
            cur = {mem_addr, mem_din, mem_be};
            if (acked && mem_req === 1'b1) ack_viol++;
            acked = 0;
            if (mem_req === 1'b1) begin
                if (!seen) begin
                    first_word = cur;
                    seen = 1;
                end else if (cur !== first_word) begin
                    unstable_cnt++;
                end
                if (ack_en) begin
                    wait_cnt++;
                    if (wait_cnt >= 2) begin
                        cap_q.push_back(cur);
                        ack_resp = 1'b1;
                        acked = 1;
                        wait_cnt = 0;
                        seen = 0;
                    end
                end
            end else begin
                seen = 0;
                wait_cnt = 0;
            end
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed no finish expected finish within 5ms");
        $fatal(1, "watchdog");
    end

    // Reference model: byte stream -> expected word stream.
    logic          m_pv = 1'b0;
    logic [AW-1:0] m_pa = '0;
    logic [7:0]    m_pd = '0;
    int            m_bytes = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_byte(input logic [26:0] a, input logic [7:0] d);
        logic [AW-1:0] wa;
        wa = a[AW:1];
        m_bytes++;
        if (!a[0]) begin
            if (m_pv) exp_q.push_back({m_pa, 8'h00, m_pd, 2'b01});
            m_pv = 1'b1; m_pa = wa; m_pd = d;
        end else if (m_pv && m_pa == wa) begin
            exp_q.push_back({wa, d, m_pd, 2'b11});
            m_pv = 1'b0;
        end else begin
            if (m_pv) exp_q.push_back({m_pa, 8'h00, m_pd, 2'b01});
            m_pv = 1'b0;
            exp_q.push_back({wa, d, 8'h00, 2'b10});
        end
    endtask

    task automatic start_dl();
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        m_pv = 1'b0;
        m_bytes = 0;
    endtask

    task automatic write_byte(input logic [26:0] a, input logic [7:0] d, input bit respect);
        int n;
        if (respect) begin
            n = 0;
            while (clkref_n !== 1'b0 && n < 500) begin
                @(negedge clk_sys);
                n++;
            end
            check("clkref_wait", clkref_n, 1'b0);
        end
        ioctl_addr = a; ioctl_dout = d; ioctl_wr = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        model_byte(a, d);
    endtask

    task automatic end_dl();
        int n, start;
        start = dl_done_cnt;
        ioctl_download = 1'b0;
        if (m_pv) exp_q.push_back({m_pa, 8'h00, m_pd, 2'b01});
        m_pv = 1'b0;
        n = 0;
        do begin
            @(negedge clk_sys); #1;
            n++;
        end while (dl_done_cnt == start && n < 400);
        check("dl_done_seen", dl_done_cnt != start, 1'b1);
        repeat (3) @(negedge clk_sys);
        #1;
        check("dl_done_once", dl_done_cnt - start, 1);
        check("byte_count", byte_count, m_bytes);
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_nwords"}, cap_q.size(), exp_q.size());
        while (exp_q.size() > 0 && cap_q.size() > 0)
            check(tag, cap_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        cap_q.delete();
    endtask

    initial begin
        int len, start_dc;
        logic [26:0] a;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("rst_mem_req", mem_req, 1'b0);
        check("rst_mem_be", mem_be, 2'b00);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_din", mem_din, 0);
        check("rst_clkref_n", clkref_n, 1'b0);
        check("rst_dl_done", dl_done, 1'b0);
        check("rst_overflow", overflow, 1'b0);
        check("rst_byte_count", byte_count, 0);
        rst_n = 1'b1;
        @(negedge clk_sys);
        ack_en = 1'b1;

        // Four bytes -> two full words
        start_dl();
        write_byte(27'd0, 8'h11, 1); write_byte(27'd1, 8'h22, 1);
        write_byte(27'd2, 8'h33, 1); write_byte(27'd3, 8'h44, 1);
        end_dl();
        check("four_w0", cap_q[0], {24'd0, 16'h2211, 2'b11});
        check("four_w1", cap_q[1], {24'd1, 16'h4433, 2'b11});
        compare_q("four_bytes");

        // Odd length -> trailing low byte flushed with be=01
        start_dl();
        write_byte(27'd0, 8'hA1, 1); write_byte(27'd1, 8'hB2, 1);
        write_byte(27'd2, 8'hC3, 1);
        end_dl();
        check("odd_last", cap_q[1], {24'd1, 16'h00C3, 2'b01});
        compare_q("odd_len");

        // Lone odd byte -> high lane only
        start_dl();
        write_byte(27'd5, 8'hAB, 1);
        end_dl();
        check("lone_odd", cap_q[0], {24'd2, 16'hAB00, 2'b10});
        compare_q("lone_odd");

        // Randomized downloads
        for (int t = 0; t < 10; t++) begin
            start_dl();
            len = $urandom_range(1, 20);
            a = 27'($urandom_range(0, 31));
            for (int i = 0; i < len; i++) begin
                write_byte(a, 8'($urandom), 1);
                repeat ($urandom_range(0, 2)) @(negedge clk_sys);
                if ($urandom_range(0, 3) == 0) a = 27'($urandom_range(0, 63));
                else a = a + 27'd1;
            end
            end_dl();
            compare_q("rand_dl");
        end

        // Back-pressure: acks withheld, throttle must rise at occupancy 2
        ack_en = 1'b0;
        start_dl();
        write_byte(27'd0, 8'h01, 1); write_byte(27'd1, 8'h02, 1);
        check("bp_clkref_occ1", clkref_n, 1'b0);
        write_byte(27'd2, 8'h03, 1); write_byte(27'd3, 8'h04, 1);
        check("bp_clkref_occ2", clkref_n, 1'b1);
        repeat (5) @(negedge clk_sys);
        check("bp_clkref_hold", clkref_n, 1'b1);
        check("bp_no_overflow", overflow, 1'b0);
        ack_en = 1'b1;
        for (int i = 4; i < 10; i++) write_byte(27'(i), 8'(i * 3 + 1), 1);
        end_dl();
        compare_q("backpressure");

        // Forced writes into a full FIFO -> overflow, first DEPTH words kept
        ack_en = 1'b0;
        start_dl();
        for (int i = 0; i < 12; i++) write_byte(27'(16 + i), 8'($urandom), 0);
        check("ovf_set", overflow, 1'b1);
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        ack_en = 1'b1;
        end_dl();
        check("ovf_sticky", overflow, 1'b1);
        compare_q("overflow");
        start_dl();
        check("ovf_cleared", overflow, 1'b0);
        check("bc_cleared", byte_count, 0);
        end_dl();
        compare_q("empty_dl");

        // Reset during an outstanding request
        ack_en = 1'b0;
        start_dl();
        write_byte(27'd8, 8'h5A, 1); write_byte(27'd9, 8'hA5, 1);
        repeat (2) @(negedge clk_sys);
        check("pre_rst_req", mem_req, 1'b1);
        rst_n = 1'b0; ioctl_download = 1'b0;
        @(negedge clk_sys);
        rst_n = 1'b1;
        check("rst_drops_req", mem_req, 1'b0);
        start_dc = dl_done_cnt;
        stray_ack = 1'b1;
        @(negedge clk_sys);
        stray_ack = 1'b0;
        repeat (3) @(negedge clk_sys);
        check("stray_no_req", mem_req, 1'b0);
        check("stray_no_done", dl_done_cnt, start_dc);
        exp_q.delete();
        cap_q.delete();
        ack_en = 1'b1;
        start_dl();
        write_byte(27'd10, 8'h77, 1); write_byte(27'd11, 8'h88, 1);
        end_dl();
        compare_q("after_rst");

        check("req_stable", unstable_cnt, 0);
        check("req_low_after_ack", ack_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
